ts_packet_gen: RTL

- MPEG-2 TS packet transmitter: the source end of the stream our continuity-counter checker consumes.
- Emits 188-byte packets as a byte stream with a valid/ready handshake.
- Each packet is a 4-byte header (sync 0x47, PID, PUSI, continuity counter) followed by 184 deterministic payload bytes.
- Packet starts are paced by the same `timer_in` interval mechanism the checker uses; the block drives checker benches and loopback QoS tests.

---
 rtl/ts_pkg.sv | 45 ++++
 rtl/ts_hdr_mux.sv | 32 +++
 rtl/ts_packet_gen.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ts_pkg.sv
// Shared MPEG-2 TS constants, header layout and state type.
// Used by the packet generator and by the continuity-counter checker.
package ts_pkg;

    localparam logic [7:0]  TS_SYNC_BYTE   = 8'h47;
    localparam int unsigned TS_PKT_LEN     = 188;
    localparam int unsigned TS_HDR_LEN     = 4;
    localparam logic [1:0]  TS_AFC_PAYLOAD = 2'b01;
    localparam logic [12:0] TS_NULL_PID    = 13'h1FFF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ts_state_e;

    // Header bytes 1..3 as transmitted, MSB first.
    typedef struct packed {
        logic        tei;
        logic        pusi;
        logic        prio;
        logic [12:0] pid;
        logic [1:0]  scrambling;
        logic [1:0]  afc;
        logic [3:0]  cc;
    } ts_hdr_t;

    function automatic ts_hdr_t ts_make_hdr(input logic [12:0] pid, input logic pusi,
                                            input logic [3:0] cc);
        ts_hdr_t h;
        h.tei        = 1'b0;
        h.pusi       = pusi;
        h.prio       = 1'b0;
        h.pid        = pid;
        h.scrambling = 2'b00;
        h.afc        = TS_AFC_PAYLOAD;
        h.cc         = cc;
        return h;
    endfunction

    // A skip advances by two, leaving a hole the checker must flag.
    function automatic logic [3:0] ts_cc_next(input logic [3:0] cc, input logic skip);
        return cc + (skip ? 4'd2 : 4'd1);
    endfunction

endpackage

// File: rtl/ts_hdr_mux.sv
// Combinational TS byte selector: header fields for the first bytes, then a
// deterministic payload ramp starting at 0x00.
module ts_hdr_mux
    import ts_pkg::*;
#(
    parameter int unsigned HDR_LEN = TS_HDR_LEN
) (
    input  logic [7:0]  idx_i,
    input  logic [12:0] pid_i,
    input  logic        pusi_i,
    input  logic [3:0]  cc_i,
    output logic [7:0]  data_o
);

    ts_hdr_t     hdr;
    logic [23:0] hdr_bits;

    assign hdr      = ts_make_hdr(pid_i, pusi_i, cc_i);
    assign hdr_bits = hdr;

    always_comb begin
        data_o = idx_i - 8'(HDR_LEN);
        case (idx_i)
            8'd0:    data_o = TS_SYNC_BYTE;
            8'd1:    data_o = hdr_bits[23:16];
            8'd2:    data_o = hdr_bits[15:8];
            8'd3:    data_o = hdr_bits[7:0];
            default: ;
        endcase
    end

endmodule

// File: rtl/ts_packet_gen.sv
// MPEG-2 TS packet source with valid/ready byte stream and timer-paced starts.
// Optional CC_ERR_INJECT_EN adds err_inject to force a continuity-counter skip.
module ts_packet_gen
    import ts_pkg::*;
#(
    parameter int unsigned PKT_LEN = TS_PKT_LEN,
    parameter int unsigned HDR_LEN = TS_HDR_LEN,
    parameter logic [3:0]  CC_INIT = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] timer_in,
    input  logic [12:0] pid,
    input  logic        pusi,
    input  logic        ts_ready,
`ifdef CC_ERR_INJECT_EN
    input  logic        err_inject,
`endif
    output logic [7:0]  ts_data,
    output logic        ts_valid,
    output logic        ts_sop,
    output logic        ts_eop,
    output logic [3:0]  cc_out,
    output logic [15:0] pkt_count,
    output logic        busy
);

    localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

    ts_state_e   state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  idx_q, idx_d;
    logic [12:0] pid_l_q, pid_l_d;
    logic        pusi_l_q, pusi_l_d;
    logic [3:0]  cc_q, cc_d;
    logic [15:0] pkt_count_q, pkt_count_d;

    logic       start;
    logic       xfer;
    logic       eop_xfer;
    logic       skip;
    logic [7:0] mux_data;

    // Starts are only evaluated in IDLE, which forces a bubble after every eop.
    assign start    = (state_q == IDLE) && en && (timer_q >= timer_in);
    assign xfer     = (state_q == SEND) && ts_ready;
    assign eop_xfer = xfer && (idx_q == LAST_IDX);

`ifdef CC_ERR_INJECT_EN
    logic inj_q, inj_d;

    assign skip  = inj_q | err_inject;
    assign inj_d = eop_xfer ? 1'b0 : skip;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inj_q <= 1'b0;
        end else begin
            inj_q <= inj_d;
        end
    end
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        timer_d = timer_q;
        if (start) begin
            timer_d = '0;
        end else if (!en && (state_q == IDLE)) begin
            timer_d = '0;
        end else if (en && (timer_q != 16'hFFFF)) begin
            timer_d = timer_q + 16'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pid_l_d     = pid_l_q;
        pusi_l_d    = pusi_l_q;
        cc_d        = cc_q;
        pkt_count_d = pkt_count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SEND;
                    idx_d    = '0;
                    pid_l_d  = pid;
                    pusi_l_d = pusi;
                end
            end
            SEND: begin
                if (eop_xfer) begin
                    state_d     = IDLE;
                    idx_d       = '0;
                    cc_d        = ts_cc_next(cc_q, skip);
                    pkt_count_d = pkt_count_q + 16'd1;
                end else if (xfer) begin
                    idx_d = idx_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            idx_q       <= '0;
            pid_l_q     <= '0;
            pusi_l_q    <= 1'b0;
            cc_q        <= CC_INIT;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            pid_l_q     <= pid_l_d;
            pusi_l_q    <= pusi_l_d;
            cc_q        <= cc_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    ts_hdr_mux #(
        .HDR_LEN (HDR_LEN)
    ) u_hdr_mux (
        .idx_i  (idx_q),
        .pid_i  (pid_l_q),
        .pusi_i (pusi_l_q),
        .cc_i   (cc_q),
        .data_o (mux_data)
    );

    // Outputs derive from state registers only, so reset drops ts_valid at once.
    assign ts_valid  = (state_q == SEND);
    assign ts_data   = ts_valid ? mux_data : 8'h00;
    assign ts_sop    = ts_valid && (idx_q == 8'd0);
    assign ts_eop    = ts_valid && (idx_q == LAST_IDX);
    assign busy      = ts_valid;
    assign cc_out    = cc_q;
    assign pkt_count = pkt_count_q;

endmodule
